gf16_inv_stage2: RTL and testbench
==================================

# gf16_inv_stage2

Second pipeline stage of the two-share, first-order masked AES S-box; it sits directly downstream of the stage that produces the masked GF(2^4) value d = (h+l)^2·ν + h·l and the one-cycle-delayed shares of h and l. The block inverts d in GF(2^4) under masking, using the GF(2^2) tower and DOM-style multipliers with fresh randomness. It forwards the h/l shares, aligned to its own 2-cycle latency, so the downstream output-multiplication stage receives matched operands.

## Interface
Parameters: none. All field constants come from the shared tower package.

- CLK  input  1  rising-edge clock
- RST  input  1  reset, synchronous, active-high
- in_valid  input  1  d0/d1 and h/l shares are valid this cycle
- d0, d1  input  4 each  shares of d (d = d0 ^ d1)
- h0, h1, l0, l1  input  4 each  shares of h and l, already one cycle delayed by the upstream stage
- r0, r1, r2  input  2 each  fresh uniform masks, one per GF(2^2) masked multiplier; new values every cycle
- out_valid  output  1  outputs hold the result for an in_valid issued 2 cycles earlier
- inv0, inv1  output  4 each  shares of d^-1 (inverse of 0 is defined as 0)
- ho0, ho1, lo0, lo1  output  4 each  h/l shares delayed by 2 cycles

## Operation
- Representation is Canright's normal basis:
  - GF(2^4) element = (γ1 high, γ0 low) in GF(2^2).
  - GF(2^2) uses basis {W^2, W}. Squaring there is a bit swap, and so is inversion.
  - Unit element is 2'b11 in GF(2^2) and 4'b1111 in GF(2^4). N = W^2 is the codebase constant.
- Cycle A, combinational, then registered into register bank A:
  - θ shares: θ_i = sq_scl_N(γ1_i ^ γ0_i) ^ (γ1_i·γ0_i) + the DOM cross term.
  - Cross terms (γ1_0·γ0_1 ^ r0) and (γ1_1·γ0_0 ^ r0) are each registered separately, then folded into shares 0 and 1 respectively.
  - γ1_i, γ0_i, and the h/l shares pass through into register bank A.
- Cycle B:
  - θ^-1 is computed share-wise as the bit swap of each θ share (linear, no randomness).
  - Two DOM multipliers form the output halves:
    - output high = θ^-1·γ0, using r1
    - output low = θ^-1·γ1, using r2
  - Results go into register bank B and drive inv0/inv1.
- Shares never recombine. Every nonlinear cross-domain product is registered with its fresh mask before any XOR with the other domain.
- Data registers load every cycle regardless of in_valid; only the valid flag gates meaning.
- A valid shift register (2 bits) carries in_valid to out_valid.

## Timing
- Latency is exactly 2 cycles: in_valid at edge k gives out_valid=1 and results on edge k+2.
- Throughput is one new input per cycle. There are no stalls and no backpressure.
- Reset: on any edge with RST=1, all data registers, the valid pipe, out_valid, inv0/inv1, ho*/lo* are cleared to 0.
- Reset mid-operation: in-flight items are dropped. out_valid stays 0 for the first 2 edges after RST deasserts, unless new in_valid arrives.
- RST has priority over in_valid on the same edge.
- Back-to-back valids must produce back-to-back out_valid with no bubbles.
- Functional correctness means (inv0^inv1) = (d0^d1)^-1 for any share split and any r0..r2.

## Structure
- Shared package gets:
  - the GF(2^2)/GF(2^4) normal-basis constants (N, unit),
  - the sq_scl_N and GF(2^2) square functions,
  - 2-/4-bit share typedefs.
- One sub-module: gf4_dom_mul. It computes the two inner products combinationally, registers the two masked cross terms, and outputs the share pair. It is instantiated three times.

## Test plan
- Reset: hold RST with random inputs for 3 cycles. Required: all outputs 0 and out_valid=0; after release with in_valid=0, out_valid stays 0.
- Unit: d0=4'hA, d1=4'h5 (d=4'hF), random masks. Required: inv0^inv1=4'hF at k+2 with out_valid=1.
- Zero: d0=d1=4'h6 (d=0). Required: inv0^inv1=4'h0.
- Exhaustive: stream all 16 d values × 8 random share splits back-to-back. Required:
  - out_valid=1 continuously,
  - d·(inv0^inv1)=1 for d≠0, checked with the package multiplier,
  - ho*/lo* equal h*/l* from 2 cycles earlier.
- Mid-stream reset: assert RST for 1 cycle during a 4-item burst. Required: the items in flight are dropped; the next input after release appears exactly 2 cycles later.
- Mask independence: fix d=4'h3 and sweep r0..r2 over all 64 values. Required: identical recombined inverse every time.

Source files
------------

// File: rtl/gf16_inv_stage2_pkg.sv
// Canright normal-basis tower constants, field helpers and share types shared by
// the masked GF(2^4) inversion stage. GF(2^2) bit1 = coefficient of W, bit0 = coefficient of W^2.
package gf16_inv_stage2_pkg;

    typedef logic [1:0] gf4_t;
    typedef logic [3:0] gf16_t;

    typedef struct packed {
        gf4_t sh1;
        gf4_t sh0;
    } gf4_sh_t;

    typedef struct packed {
        gf16_t h0;
        gf16_t h1;
        gf16_t l0;
        gf16_t l1;
    } hl_sh_t;

    localparam gf4_t  GF4_N    = 2'b01;
    localparam gf4_t  GF4_ONE  = 2'b11;
    localparam gf16_t GF16_ONE = {GF4_ONE, GF4_ONE};

    function automatic gf4_t gf4_sq(input gf4_t a);
        return {a[0], a[1]};
    endfunction

    // In GF(2^2) a^-1 = a^2 for every a (0 maps to 0).
    function automatic gf4_t gf4_inv(input gf4_t a);
        return gf4_sq(a);
    endfunction

    function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    function automatic gf4_t gf4_scl_n(input gf4_t a);
        return gf4_mul(a, GF4_N);
    endfunction

    function automatic gf4_t gf4_sq_scl_n(input gf4_t a);
        return gf4_scl_n(gf4_sq(a));
    endfunction

    function automatic gf16_t gf16_mul(input gf16_t a, input gf16_t b);
        gf4_t e;
        gf4_t p;
        gf4_t q;
        e = gf4_scl_n(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        p = gf4_mul(a[3:2], b[3:2]) ^ e;
        q = gf4_mul(a[1:0], b[1:0]) ^ e;
        return {p, q};
    endfunction

endpackage

// File: rtl/gf16_inv_stage2_if.sv
// Operand/result bundle of the masked inversion stage: d, h, l shares and fresh masks in,
// inverse shares and aligned h/l shares out.
interface gf16_inv_stage2_if;
    import gf16_inv_stage2_pkg::*;

    logic  in_valid;
    gf16_t d0;
    gf16_t d1;
    gf16_t h0;
    gf16_t h1;
    gf16_t l0;
    gf16_t l1;
    gf4_t  r0;
    gf4_t  r1;
    gf4_t  r2;

    logic  out_valid;
    gf16_t inv0;
    gf16_t inv1;
    gf16_t ho0;
    gf16_t ho1;
    gf16_t lo0;
    gf16_t lo1;

    modport master (
        output in_valid, d0, d1, h0, h1, l0, l1, r0, r1, r2,
        input  out_valid, inv0, inv1, ho0, ho1, lo0, lo1
    );

    modport slave (
        input  in_valid, d0, d1, h0, h1, l0, l1, r0, r1, r2,
        output out_valid, inv0, inv1, ho0, ho1, lo0, lo1
    );

endinterface

// File: rtl/gf16_inv_stage2_gf4_dom_mul.sv
// Two-share DOM GF(2^2) multiplier: inner and masked cross products are registered
// separately and only combined within a share domain after the register.
module gf4_dom_mul
    import gf16_inv_stage2_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  gf4_sh_t a_i,
    input  gf4_sh_t b_i,
    input  gf4_t    r_i,
    output gf4_sh_t z_o
);

    gf4_t inner0_d;
    gf4_t inner1_d;
    gf4_t cross01_d;
    gf4_t cross10_d;
    gf4_t inner0_q;
    gf4_t inner1_q;
    gf4_t cross01_q;
    gf4_t cross10_q;

    assign inner0_d  = gf4_mul(a_i.sh0, b_i.sh0);
    assign inner1_d  = gf4_mul(a_i.sh1, b_i.sh1);
    assign cross01_d = gf4_mul(a_i.sh0, b_i.sh1) ^ r_i;
    assign cross10_d = gf4_mul(a_i.sh1, b_i.sh0) ^ r_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inner0_q  <= '0;
            inner1_q  <= '0;
            cross01_q <= '0;
            cross10_q <= '0;
        end else begin
            inner0_q  <= inner0_d;
            inner1_q  <= inner1_d;
            cross01_q <= cross01_d;
            cross10_q <= cross10_d;
        end
    end

    assign z_o = '{sh1: inner1_q ^ cross10_q, sh0: inner0_q ^ cross01_q};

endmodule

// File: rtl/gf16_inv_stage2.sv
// Masked GF(2^4) inversion in the Canright tower, two register banks deep, with the
// h/l shares delayed alongside so the next stage receives aligned operands.
module gf16_inv_stage2
    import gf16_inv_stage2_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    gf16_inv_stage2_if.slave stage_if
);

    gf4_sh_t    g1_d;
    gf4_sh_t    g0_d;
    gf4_sh_t    g1_q;
    gf4_sh_t    g0_q;
    hl_sh_t     hl_a_d;
    hl_sh_t     hl_a_q;
    hl_sh_t     hl_b_q;
    logic [1:0] vld_d;
    logic [1:0] vld_q;
    gf4_sh_t    prod_q;
    gf4_sh_t    theta;
    gf4_sh_t    theta_inv;
    gf4_sh_t    out_hi;
    gf4_sh_t    out_lo;

    assign g1_d   = '{sh1: stage_if.d1[3:2], sh0: stage_if.d0[3:2]};
    assign g0_d   = '{sh1: stage_if.d1[1:0], sh0: stage_if.d0[1:0]};
    assign hl_a_d = '{h0: stage_if.h0, h1: stage_if.h1, l0: stage_if.l0, l1: stage_if.l1};
    assign vld_d  = {vld_q[0], stage_if.in_valid};

    // gamma1 * gamma0, the only nonlinear part of theta
    gf4_dom_mul u_mul_theta (
        .clk_i (CLK),
        .rst_i (RST),
        .a_i   (g1_d),
        .b_i   (g0_d),
        .r_i   (stage_if.r0),
        .z_o   (prod_q)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            g1_q   <= '0;
            g0_q   <= '0;
            hl_a_q <= '0;
            hl_b_q <= '0;
            vld_q  <= '0;
        end else begin
            g1_q   <= g1_d;
            g0_q   <= g0_d;
            hl_a_q <= hl_a_d;
            hl_b_q <= hl_a_q;
            vld_q  <= vld_d;
        end
    end

    // Linear terms are added share-wise, so no mask is needed here.
    always_comb begin
        theta.sh0     = gf4_sq_scl_n(g1_q.sh0 ^ g0_q.sh0) ^ prod_q.sh0;
        theta.sh1     = gf4_sq_scl_n(g1_q.sh1 ^ g0_q.sh1) ^ prod_q.sh1;
        theta_inv.sh0 = gf4_inv(theta.sh0);
        theta_inv.sh1 = gf4_inv(theta.sh1);
    end

    gf4_dom_mul u_mul_hi (
        .clk_i (CLK),
        .rst_i (RST),
        .a_i   (theta_inv),
        .b_i   (g0_q),
        .r_i   (stage_if.r1),
        .z_o   (out_hi)
    );

    gf4_dom_mul u_mul_lo (
        .clk_i (CLK),
        .rst_i (RST),
        .a_i   (theta_inv),
        .b_i   (g1_q),
        .r_i   (stage_if.r2),
        .z_o   (out_lo)
    );

    assign stage_if.out_valid = vld_q[1];
    assign stage_if.inv0      = {out_hi.sh0, out_lo.sh0};
    assign stage_if.inv1      = {out_hi.sh1, out_lo.sh1};
    assign stage_if.ho0       = hl_b_q.h0;
    assign stage_if.ho1       = hl_b_q.h1;
    assign stage_if.lo0       = hl_b_q.l0;
    assign stage_if.lo1       = hl_b_q.l1;

endmodule

// File: tb/tb_gf16_inv_stage2.sv
// Directed bench for gf16_inv_stage2: inverse found by exhaustive search over the field,
// history of sampled inputs gives the expected output two edges later.
module tb_gf16_inv_stage2;
    import gf16_inv_stage2_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    gf16_inv_stage2_if bus ();

    gf16_inv_stage2 dut (
        .CLK      (clk),
        .RST      (rst),
        .stage_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] d;
        logic [3:0] h0;
        logic [3:0] h1;
        logic [3:0] l0;
        logic [3:0] l1;
    } samp_t;

    samp_t hist[$];

    function automatic logic [3:0] ref_inv(input logic [3:0] d);
        for (int x = 0; x < 16; x++) begin
            if (gf16_mul(d, 4'(x)) == GF16_ONE) return 4'(x);
        end
        return 4'h0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        samp_t s;
        s.rst = rst;
        s.vld = bus.in_valid;
        s.d   = bus.d0 ^ bus.d1;
        s.h0  = bus.h0;
        s.h1  = bus.h1;
        s.l0  = bus.l0;
        s.l1  = bus.l1;
        hist.push_back(s);
    end

    always @(negedge clk) begin
        samp_t      cur;
        samp_t      prv;
        logic [3:0] rec;
        if (hist.size() >= 2) begin
            cur = hist[hist.size() - 1];
            prv = hist[hist.size() - 2];
            rec = bus.inv0 ^ bus.inv1;
            if (cur.rst) begin
                check("rst_out_valid", 8'(bus.out_valid), 8'h00);
                check("rst_inv_shares", {bus.inv1, bus.inv0}, 8'h00);
                check("rst_ho", {bus.ho1, bus.ho0}, 8'h00);
                check("rst_lo", {bus.lo1, bus.lo0}, 8'h00);
            end else begin
                check("out_valid", 8'(bus.out_valid), 8'(prv.vld & ~prv.rst));
                if (prv.rst) begin
                    check("post_rst_inv", 8'(rec), 8'h00);
                    check("post_rst_ho", {bus.ho1, bus.ho0}, 8'h00);
                    check("post_rst_lo", {bus.lo1, bus.lo0}, 8'h00);
                end else if (prv.vld) begin
                    check("inv_model", 8'(rec), 8'(ref_inv(prv.d)));
                    if (prv.d != 4'h0)
                        check("d_times_inv", 8'(gf16_mul(prv.d, rec)), 8'(GF16_ONE));
                    check("ho_delay", {bus.ho1, bus.ho0}, {prv.h1, prv.h0});
                    check("lo_delay", {bus.lo1, bus.lo0}, {prv.l1, prv.l0});
                    if (prv.d == 4'hF) check("unit_lit", 8'(rec), 8'h0F);
                    if (prv.d == 4'h0) check("zero_lit", 8'(rec), 8'h00);
                    if (prv.d == 4'h3) check("inv3_lit", 8'(rec), 8'h08);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic [3:0] s0, input logic [3:0] s1,
                         input logic fix_m, input logic [5:0] m);
        rst          = r;
        bus.in_valid = v;
        bus.d0       = s0;
        bus.d1       = s1;
        bus.h0       = 4'($urandom);
        bus.h1       = 4'($urandom);
        bus.l0       = 4'($urandom);
        bus.l1       = 4'($urandom);
        if (fix_m) {bus.r0, bus.r1, bus.r2} = m;
        else       {bus.r0, bus.r1, bus.r2} = 6'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic r, input logic [3:0] d);
        logic [3:0] s;
        s = 4'($urandom);
        drive(v, r, s, s ^ d, 1'b0, 6'd0);
    endtask

    initial begin
        logic [3:0] s;

        // pin the reference model to hand-derived inverses
        check("model_inv0", 8'(ref_inv(4'h0)), 8'h00);
        check("model_inv1", 8'(ref_inv(4'h1)), 8'h04);
        check("model_inv3", 8'(ref_inv(4'h3)), 8'h08);
        check("model_inv6", 8'(ref_inv(4'h6)), 8'h0E);
        check("model_invF", 8'(ref_inv(4'hF)), 8'h0F);

        repeat (3) drive_d(1'b1, 1'b1, 4'($urandom));
        repeat (3) drive_d(1'b0, 1'b0, 4'($urandom));

        drive(1'b1, 1'b0, 4'hA, 4'h5, 1'b0, 6'd0);
        repeat (2) drive_d(1'b0, 1'b0, 4'h0);

        drive(1'b1, 1'b0, 4'h6, 4'h6, 1'b0, 6'd0);
        repeat (2) drive_d(1'b0, 1'b0, 4'h0);

        for (int d = 0; d < 16; d++)
            for (int k = 0; k < 8; k++)
                drive_d(1'b1, 1'b0, 4'(d));
        repeat (2) drive_d(1'b0, 1'b0, 4'h0);

        drive_d(1'b1, 1'b0, 4'h1);
        drive_d(1'b1, 1'b0, 4'h6);
        drive_d(1'b1, 1'b1, 4'h9);
        drive_d(1'b1, 1'b0, 4'hC);
        repeat (3) drive_d(1'b0, 1'b0, 4'h0);

        for (int m = 0; m < 64; m++) begin
            s = 4'($urandom);
            drive(1'b1, 1'b0, s, s ^ 4'h3, 1'b1, 6'(m));
        end
        repeat (3) drive_d(1'b0, 1'b0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
